// File: rtl/memoria_dados_param_pkg.sv
// rtl/memoria_dados_param_pkg.sv - shared types and limits for the parametrised data memory
package memoria_pkg;

    typedef enum logic {
        LIMPANDO = 1'b0,
        OPERANDO = 1'b1
    } estado_t;

    localparam int LATENCIA_MAX = 4;

endpackage

// File: rtl/memoria_dados_param_linha_atraso.sv
// rtl/memoria_dados_param_linha_atraso.sv - clearable shift register carrying {valido, erro, dado}
module linha_atraso #(
    parameter int LARGURA = 8,
    parameter int PROF    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LARGURA+1:0] entrada,
    output logic [LARGURA+1:0] saida
);

    generate
        if (PROF == 0) begin : g_direto
            logic unused_sinais;
            assign unused_sinais = clk ^ rst;
            assign saida = entrada;
        end else begin : g_registrado
            logic [LARGURA+1:0] estagio [PROF];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PROF; i++) begin
                        estagio[i] <= '0;
                    end
                end else begin
                    estagio[0] <= entrada;
                    for (int i = 1; i < PROF; i++) begin
                        estagio[i] <= estagio[i-1];
                    end
                end
            end

            assign saida = estagio[PROF-1];
        end
    endgenerate

endmodule

// File: rtl/memoria_dados_param.sv
// rtl/memoria_dados_param.sv - pipelined single-port data memory with optional post-reset zeroing sweep
module memoria_dados_param
    import memoria_pkg::*;
#(
    parameter int  LARGURA         = 8,
    parameter int  PROFUNDIDADE    = 256,
    parameter int  LATENCIA        = 1,
    parameter int  LIMPAR_NO_RESET = 1,
    localparam int LARG_END        = $clog2(PROFUNDIDADE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valido,
    input  logic                writeEnable,
    input  logic [LARG_END-1:0] endereco,
    input  logic [LARGURA-1:0]  dadoEntrada,
    output logic                pronto,
    output logic [LARGURA-1:0]  dadoSaida,
    output logic                saidaValida,
    output logic                erroEndereco,
    output logic                ocupado
);

    localparam int PROF_LINHA = ((LATENCIA > LATENCIA_MAX) ? LATENCIA_MAX : LATENCIA) - 1;
    localparam logic [LARG_END:0]   PROF_LIM = (LARG_END+1)'(PROFUNDIDADE);
    localparam logic [LARG_END-1:0] ULT_END  = LARG_END'(PROFUNDIDADE - 1);
    localparam estado_t ESTADO_INICIAL = (LIMPAR_NO_RESET != 0) ? LIMPANDO : OPERANDO;

    typedef struct packed {
        logic               erro;
        logic [LARGURA-1:0] dado;
    } resposta_t;

    estado_t             estado;
    estado_t             prox_estado;
    logic [LARG_END-1:0] contador;
    logic [LARGURA-1:0]  mem [PROFUNDIDADE];

    logic                aceita;
    logic                em_faixa;
    resposta_t           resp_req;
    resposta_t           resp_fim;
    logic                valido_fim;
    logic [LARGURA+1:0]  linha_saida;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= ESTADO_INICIAL;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        if (estado == LIMPANDO && contador == ULT_END) begin
            prox_estado = OPERANDO;
        end
    end

    always_comb begin
        pronto  = (estado == OPERANDO) && !rst;
        ocupado = (estado == LIMPANDO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contador <= '0;
        end else if (estado == LIMPANDO) begin
            contador <= contador + 1'b1;
        end
    end

    // Read path sees the array before this edge's write; writes echo their own data.
    always_comb begin
        em_faixa      = ({1'b0, endereco} < PROF_LIM);
        aceita        = valido && pronto;
        resp_req.erro = aceita && !em_faixa;
        if (!em_faixa) begin
            resp_req.dado = '0;
        end else if (writeEnable) begin
            resp_req.dado = dadoEntrada;
        end else begin
            resp_req.dado = mem[endereco];
        end
    end

    always_ff @(posedge clk) begin
        if (estado == LIMPANDO) begin
            mem[contador] <= '0;
        end else if (aceita && writeEnable && em_faixa) begin
            mem[endereco] <= dadoEntrada;
        end
    end

    linha_atraso #(
        .LARGURA (LARGURA),
        .PROF    (PROF_LINHA)
    ) u_linha_atraso (
        .clk     (clk),
        .rst     (rst),
        .entrada ({aceita, resp_req}),
        .saida   (linha_saida)
    );

    assign {valido_fim, resp_fim} = linha_saida;

    // Final stage doubles as the hold register for dadoSaida between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            saidaValida  <= 1'b0;
            erroEndereco <= 1'b0;
            dadoSaida    <= '0;
        end else begin
            saidaValida  <= valido_fim;
            erroEndereco <= valido_fim && resp_fim.erro;
            if (valido_fim) begin
                dadoSaida <= resp_fim.dado;
            end
        end
    end

endmodule

// File: doc/memoria_dados_param.md
Name: memoria_dados_param

Overview:
Parametrised successor to the single-port data memory. It has configurable word width, depth and read latency, plus a valid/ready request handshake. An optional post-reset clear sequence zeroes every word before the block accepts requests. It sits between the CPU datapath load/store stage and the data store, and replaces the fixed 8x256 single-cycle data memory.

Parameters:
LARGURA, 8, data word width in bits (>=1)
PROFUNDIDADE, 256, number of words (>=2, need not be a power of 2)
LATENCIA, 1, cycles from accepted request to saidaValida (1..4)
LIMPAR_NO_RESET, 1, 1 = run the zeroing sweep after reset; 0 = memory contents are undefined after reset
LARG_END, $clog2(PROFUNDIDADE), address width (derived, not overridden)

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  reset, asynchronous, active-high
valido  in  1  request present this cycle
writeEnable  in  1  1 = write request, 0 = read request
endereco  in  LARG_END  word address
dadoEntrada  in  LARGURA  write data
pronto  out  1  block accepts a request this cycle
dadoSaida  out  LARGURA  response data
saidaValida  out  1  dadoSaida valid this cycle (one-cycle pulse per response)
erroEndereco  out  1  response belongs to an out-of-range address; aligned with saidaValida
ocupado  out  1  clear sweep in progress

Behaviour:
- Clock port is clk, reset port is rst. Reset is asynchronous and active-high, single clock domain.
- While rst=1: pronto=0, saidaValida=0, erroEndereco=0, dadoSaida=0, latency pipeline flushed, sweep counter=0, ocupado=LIMPAR_NO_RESET.
- FSM states: LIMPANDO and OPERANDO.
  - Reset enters LIMPANDO if LIMPAR_NO_RESET=1, otherwise OPERANDO.
- LIMPANDO:
  - Writes 0 to word[contador] and increments contador each cycle.
  - When contador=PROFUNDIDADE-1, the last word is written and the next state is OPERANDO.
  - The sweep takes exactly PROFUNDIDADE cycles after rst deasserts.
  - ocupado=1 and pronto=0 throughout. valido is ignored and no response is produced.
- OPERANDO: pronto=1 every cycle. A request is accepted at an edge where valido=1 and pronto=1.
- Write accepted at edge N:
  - word[endereco] <= dadoEntrada at edge N.
  - The response returns dadoEntrada (write-first echo).
- Read accepted at edge N: the response returns word[endereco] as stored after edge N-1's writes.
- Response timing: saidaValida=1 with data from edge N+LATENCIA-1, i.e. visible in the cycle after N+LATENCIA-1 edges.
  - LATENCIA=1 is equivalent to the legacy timing.
- Fully pipelined: one request per cycle, responses in order, no backpressure on the response side.
- Write at N followed by a read of the same address at N+1 returns the new value. No hazard stall.
- dadoSaida holds its last value when saidaValida=0.
- Out-of-range address (endereco >= PROFUNDIDADE):
  - Write is discarded.
  - The response still occurs with dadoSaida=0 and erroEndereco=1.
- rst asserted mid-sweep or mid-pipeline: in-flight responses are dropped, and the sweep restarts at address 0 after release.
- Memory array is not reset except through the sweep.

Decomposition:
- Package memoria_pkg: state enum (LIMPANDO, OPERANDO), LATENCIA_MAX=4, and a response struct {dado, erro} sized by parameter through a macro or localparam in the module.
- One sub-module, linha_atraso: a parametrised LARGURA+2-bit shift register of depth LATENCIA-1, with asynchronous clear, carrying {valido, erro, dado}.
- Array storage and FSM stay in the top module.

Test Plan:
- Reset clear: PROFUNDIDADE=16, LIMPAR_NO_RESET=1. Release rst. ocupado=1 and pronto=0 for 16 cycles, then pronto=1. Reading addresses 0..15 returns 0x00 each with erroEndereco=0.
- Write/read latency: LATENCIA=3. Write 0xA5 to addr 7, then read addr 7 back-to-back. The write echo 0xA5 pulses saidaValida 3 cycles after acceptance, the read returns 0xA5 the cycle after, and there are no gaps.
- Streaming: write addresses 0..15 with data 0x10+i on consecutive cycles, then read 15..0 consecutively. 16 consecutive saidaValida pulses arrive with data 0x1F down to 0x10, in order.
- Out of range: PROFUNDIDADE=12. Write 0x33 to addr 13, then read addr 13. Both responses have erroEndereco=1 and dadoSaida=0x00. Reading addr 1 afterwards shows it unchanged.
- Requests during sweep: valido=1 with a write to addr 2 of 0xFF while ocupado=1. No response is produced and addr 2 reads 0x00 afterwards.
- Reset mid-flight: LATENCIA=4. Issue 2 reads, then assert rst one cycle later. saidaValida stays 0 and dadoSaida=0. After release the sweep restarts from address 0 (ocupado held PROFUNDIDADE cycles).
